// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling with a per-bit
// down-counter, and a one-entry valid/ready output register with error pulses.
module uart_rx #(
   parameter int CLK_DIVIDER = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_error,
   output logic       overrun,
   output logic       busy
);
   localparam int CNT_W = $clog2(CLK_DIVIDER);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIVIDER / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLK_DIVIDER - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t           state;
   logic             rxd_p0;
   logic             rxs;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             sample;

   // Synchroniser: rxd is asynchronous, only rxs is used downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_p0 <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         rxd_p0 <= rxd;
         rxs    <= rxd_p0;
      end
   end

   assign sample = (state != IDLE) && (cnt == '0);

   // Frame FSM plus output register; busy tracks the next state so it is
   // already high in the cycle START is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (state != IDLE) cnt <= sample ? BIT_RELOAD : cnt - 1'b1;

         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  busy  <= 1'b1;
                  cnt   <= HALF_RELOAD;
               end
            end
            START: begin
               if (sample) begin
                  if (!rxs) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (sample) begin
                  shift   <= {rxs, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (sample) begin
                  if (rxs) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     // A same-cycle consume frees the register for the new byte.
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_error <= 1'b1;
                     state       <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               if (rxs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-cycle line/ready/reset script, predicts the
// outputs from frame timing arithmetic, then replays the script on the DUT.
module tb_uart_rx;
   localparam int D = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;

   bit rxd_q[$];
   bit rdy_q[$];
   bit rst_q[$];
   bit cur_rdy = 1'b1;
   int t0_55 = 0;

   uart_rx #(.CLK_DIVIDER(D)) dut (
      .clk(clk),
      .reset(reset),
      .rxd(rxd),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .frame_error(frame_error),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input bit v, input int n, input bit r = 1'b0);
      for (int i = 0; i < n; i++) begin
         rxd_q.push_back(v);
         rdy_q.push_back(cur_rdy);
         rst_q.push_back(r);
      end
   endtask

   task automatic frame(input logic [7:0] b, input bit stop);
      put(1'b0, D);
      for (int i = 0; i < 8; i++) put(b[i], D);
      put(stop, D);
   endtask

   initial begin
      int n, e, trig, ss, stop_e, end_e, r, fe_model, fe_seen, first_rise;
      bit v, ovr;
      logic [7:0] d, rb;
      logic [11:0] obs;
      bit seen[];
      bit dlv[];
      bit ferr[];
      bit bsy[];
      logic [7:0] dbyte[];
      logic [11:0] exp_q[];

      // ---------------- stimulus script ----------------
      put(1'b1, 3, 1'b1);
      put(1'b1, 50);
      t0_55 = rxd_q.size();
      frame(8'h55, 1'b1);
      put(1'b1, 300);

      cur_rdy = 1'b0;
      frame(8'hA5, 1'b1);
      frame(8'h3C, 1'b1);
      put(1'b1, 500);
      cur_rdy = 1'b1;
      put(1'b1, 100);

      frame(8'h00, 1'b0);
      put(1'b0, 5000);
      put(1'b1, 300);
      frame(8'h81, 1'b1);
      put(1'b1, 300);

      put(1'b0, 50);
      put(1'b1, 400);

      frame(8'h00, 1'b1);
      frame(8'hFF, 1'b1);
      frame(8'h5A, 1'b1);
      put(1'b1, 300);

      cur_rdy = 1'b0;
      frame(8'hC3, 1'b1);
      put(1'b1, 200);
      rb = 8'h12;
      put(1'b0, D);
      for (int i = 0; i < 4; i++) put(rb[i], D);
      put(rb[4], D / 2);
      put(rb[4], 1, 1'b1);
      cur_rdy = 1'b1;
      put(rb[4], D / 2 - 1);
      for (int i = 5; i < 8; i++) put(rb[i], D);
      put(1'b1, D);
      put(1'b1, 300);
      frame(8'h34, 1'b1);
      put(1'b1, 300);

      for (int k = 0; k < 10; k++) begin
         int kind;
         cur_rdy = bit'($urandom_range(0, 1));
         kind = $urandom_range(0, 7);
         if (kind == 0) begin
            put(1'b0, $urandom_range(1, D / 2 - 2));
         end else if (kind == 1) begin
            frame(8'($urandom), 1'b0);
            put(1'b0, $urandom_range(0, 300));
         end else begin
            frame(8'($urandom), 1'b1);
         end
         put(1'b1, $urandom_range(0, 300));
      end
      cur_rdy = 1'b1;
      put(1'b1, 500);

      // ---------------- reference model ----------------
      n = rxd_q.size();
      seen = new[n];
      dlv = new[n];
      ferr = new[n];
      bsy = new[n];
      dbyte = new[n];
      exp_q = new[n];

      // Line level the receiver acts on at edge e: two edges of latency,
      // forced high for two edges after a reset.
      for (int i = 0; i < n; i++) begin
         dbyte[i] = 8'h00;
         seen[i] = (i >= 2 && !rst_q[i-1] && !rst_q[i-2]) ? rxd_q[i-2] : 1'b1;
      end

      e = 0;
      while (e < n) begin
         if (rst_q[e] || seen[e]) begin
            e++;
            continue;
         end
         trig = e;
         ss = trig + D / 2;
         stop_e = ss + 9 * D;
         if (ss < n && seen[ss]) end_e = ss;
         else if (stop_e >= n) end_e = n;
         else if (seen[stop_e]) end_e = stop_e;
         else begin
            end_e = stop_e + 1;
            while (end_e < n && !seen[end_e]) end_e++;
         end
         r = trig + 1;
         while (r <= end_e && r < n && !rst_q[r]) r++;
         if (r <= end_e && r < n) begin
            for (int x = trig; x < r; x++) bsy[x] = 1'b1;
            if (end_e != ss && r > stop_e) ferr[stop_e] = 1'b1;
            e = r;
            continue;
         end
         for (int x = trig; x < end_e && x < n; x++) bsy[x] = 1'b1;
         if (end_e != ss && stop_e < n) begin
            if (seen[stop_e]) begin
               dlv[stop_e] = 1'b1;
               for (int i = 0; i < 8; i++) dbyte[stop_e][i] = seen[ss + (i + 1) * D];
            end else begin
               ferr[stop_e] = 1'b1;
            end
         end
         e = end_e + 1;
      end

      v = 1'b0;
      d = 8'h00;
      fe_model = 0;
      for (int i = 0; i < n; i++) begin
         ovr = 1'b0;
         if (rst_q[i]) begin
            v = 1'b0;
            d = 8'h00;
         end else if (dlv[i]) begin
            if (!v || rdy_q[i]) begin
               d = dbyte[i];
               v = 1'b1;
            end else begin
               ovr = 1'b1;
            end
         end else if (v && rdy_q[i]) begin
            v = 1'b0;
         end
         if (ferr[i]) fe_model++;
         exp_q[i] = {bsy[i], ferr[i], ovr, v, d};
      end

      // ---------------- replay on the DUT ----------------
      fe_seen = 0;
      first_rise = -1;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         rxd = rxd_q[i];
         rx_ready = rdy_q[i];
         reset = rst_q[i];
         @(negedge clk);
         obs = {busy, frame_error, overrun, rx_valid, rx_data};
         check($sformatf("cyc%0d{busy,ferr,ovr,vld,data}", i), 32'(obs), 32'(exp_q[i]));
         if (frame_error) fe_seen++;
         if (rx_valid && first_rise < 0 && i > t0_55) first_rise = i;
      end

      check("latency_0x55", 32'(first_rise - t0_55), 32'd1902);
      check("frame_error_pulses", 32'(fe_seen), 32'(fe_model));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
